// File: rtl/l2_req_queue.sv
// In-order request queue between the L2 requester and dram_ctrl.
// A read that hits a queued write to the same address is answered locally and never enqueued.
module l2_req_queue #(
    parameter int L2_REQ_WIDTH = 20,
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      l2_req_valid,
    output logic                      l2_req_ready,
    input  logic                      l2_rw_req,
    input  logic [L2_REQ_WIDTH-1:0]   l2_req_instr,
    input  logic [DATA_WIDTH-1:0]     l2_req_data,
    output logic                      ctrl_req_valid,
    input  logic                      ctrl_req_ready,
    output logic                      ctrl_rw,
    output logic [L2_REQ_WIDTH-1:0]   ctrl_instr,
    output logic [DATA_WIDTH-1:0]     ctrl_data,
    output logic                      fwd_valid,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      q_full,
    output logic                      q_empty,
    output logic [15:0]               fwd_hits
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Neither ready depends combinationally on the same side's valid.

    logic [PW-1:0]           wp;
    logic [PW-1:0]           rp;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0]        ent_rw;
    logic [L2_REQ_WIDTH-1:0] ent_instr [DEPTH];
    logic [DATA_WIDTH-1:0]   ent_data  [DEPTH];
    logic [CW-1:0]           count;

    logic                    hit;
    logic [DATA_WIDTH-1:0]   hit_data;
    logic [PW-1:0]           idx;
    logic                    accept;
    logic                    fwd_take;
    logic                    enq;
    logic                    pop;

    assign q_count        = count;
    assign q_full         = (count == CW'(DEPTH));
    assign q_empty        = (count == '0);
    assign l2_req_ready   = !q_full;
    assign ctrl_req_valid = !q_empty;

    assign ctrl_rw    = ent_valid[rp] & ent_rw[rp];
    assign ctrl_instr = ent_valid[rp] ? ent_instr[rp] : '0;
    assign ctrl_data  = ent_valid[rp] ? ent_data[rp]  : '0;

    // Scan oldest to youngest so the write nearest wp overrides older matches.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = wp - PW'(i);
            if (ent_valid[idx] && ent_rw[idx] && (ent_instr[idx] == l2_req_instr)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

    assign accept   = l2_req_valid && l2_req_ready;
    assign fwd_take = accept && !l2_rw_req && hit;
    assign enq      = accept && !fwd_take;
    assign pop      = ctrl_req_valid && ctrl_req_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_rw    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_instr[i] <= '0;
                ent_data[i]  <= '0;
            end
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
            fwd_hits  <= '0;
        end else begin
            if (pop) begin
                ent_valid[rp] <= 1'b0;
                rp            <= rp + 1'b1;
            end
            // Not full on enqueue, so wp never aliases the rp slot being cleared.
            if (enq) begin
                ent_valid[wp] <= 1'b1;
                ent_rw[wp]    <= l2_rw_req;
                ent_instr[wp] <= l2_req_instr;
                ent_data[wp]  <= l2_rw_req ? l2_req_data : '0;
                wp            <= wp + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            fwd_valid <= fwd_take;
            if (fwd_take) begin
                fwd_data <= hit_data;
                if (fwd_hits != 16'hFFFF)
                    fwd_hits <= fwd_hits + 16'd1;
            end
        end
    end

endmodule
